// File: rtl/nn_pkg.sv
// Shared definitions for the hidden-layer MAC sequencer and the weight memory.
//   mac_state_t : sequencer FSM states
//   acc_w()     : minimum accumulator width for a DATA_W x DATA_W dot product of N_IN terms
//   waddr()     : flat weight address h*N_IN+i, shared with wmem_hidden
package nn_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StShift,
        StOut,
        StDone
    } mac_state_t;

    function automatic int unsigned acc_w(int unsigned data_w, int unsigned n_in);
        return 2 * data_w + $clog2(n_in);
    endfunction

    function automatic int unsigned waddr(int unsigned h, int unsigned i, int unsigned n_in);
        return h * n_in + i;
    endfunction

endpackage

// File: rtl/hidden_mac_seq_if.sv
// Bus between hidden_mac_seq, its weight memory and the downstream activation stage.
//   start/x_in          : request and activation vector
//   raddr/rdata         : weight read port (1-cycle read latency)
//   busy                : sequencer not idle
//   out_valid/out_ready : result handshake carrying out_idx and out_acc
//   done                : one-cycle pulse after the last neuron is accepted
// master = sequencer side, slave = environment side.
interface hidden_mac_seq_if
    import nn_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned N_IN     = 8,
    parameter int unsigned N_HIDDEN = 4,
    parameter int unsigned ACC_W    = acc_w(DATA_W, N_IN)
);
    localparam int unsigned AW = $clog2(N_HIDDEN * N_IN);
    localparam int unsigned HW = $clog2(N_HIDDEN);

    logic                           start;
    logic [N_IN-1:0][DATA_W-1:0]    x_in;
    logic [AW-1:0]                  raddr;
    logic [DATA_W-1:0]              rdata;
    logic                           busy;
    logic                           out_valid;
    logic                           out_ready;
    logic [HW-1:0]                  out_idx;
    logic [ACC_W-1:0]               out_acc;
    logic                           done;

    modport master (
        input  start, x_in, rdata, out_ready,
        output raddr, busy, out_valid, out_idx, out_acc, done
    );

    modport slave (
        output start, x_in, rdata, out_ready,
        input  raddr, busy, out_valid, out_idx, out_acc, done
    );

endinterface

// File: rtl/bit_serial_mac.sv
// Bit-serial multiply-accumulate datapath: holds the current weight and the accumulator.
//   clk, rst   : clock, asynchronous active-high reset
//   i_clr      : clear accumulator
//   i_load_w   : capture i_w into the weight register
//   i_bit_en   : perform one shift/add step this cycle
//   i_bit_idx  : activation bit position b (shift amount)
//   i_x_bit    : activation bit b
//   i_is_msb   : b is the sign bit, so subtract instead of add
//   i_w        : weight from memory
//   o_acc_nxt  : accumulator value after this cycle's step
module bit_serial_mac #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 36,
    parameter int unsigned BW     = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_load_w,
    input  logic              i_bit_en,
    input  logic [BW-1:0]     i_bit_idx,
    input  logic              i_x_bit,
    input  logic              i_is_msb,
    input  logic [DATA_W-1:0] i_w,
    output logic [ACC_W-1:0]  o_acc_nxt
);
    logic [DATA_W-1:0] r_w;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  w_term;

    always_comb begin
        w_term    = {{(ACC_W - DATA_W){r_w[DATA_W-1]}}, r_w} << i_bit_idx;
        o_acc_nxt = r_acc;
        // Activation sign bit carries weight -2^(DATA_W-1).
        if (i_bit_en && i_x_bit) begin
            o_acc_nxt = i_is_msb ? (r_acc - w_term) : (r_acc + w_term);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w   <= '0;
            r_acc <= '0;
        end else begin
            if (i_load_w) begin
                r_w <= i_w;
            end
            if (i_clr) begin
                r_acc <= '0;
            end else begin
                r_acc <= o_acc_nxt;
            end
        end
    end

endmodule

// File: rtl/hidden_mac_seq.sv
// Hidden-layer dot-product sequencer: walks the weight memory row by row, feeds a
// bit-serial MAC one activation bit per cycle and presents each neuron's result on a
// valid/ready port.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : hidden_mac_seq_if.master (start/x_in, raddr/rdata, busy,
//              out_valid/out_ready/out_idx/out_acc, done)
// Build option: HIDDEN_MAC_RELU_EN clamps negative results on out_acc to zero.
module hidden_mac_seq
    import nn_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned N_IN     = 8,
    parameter int unsigned N_HIDDEN = 4,
    parameter int unsigned ACC_W    = acc_w(DATA_W, N_IN)
) (
    input  logic                clk,
    input  logic                rst,
    hidden_mac_seq_if.master    bus
);
    localparam int unsigned AW = $clog2(N_HIDDEN * N_IN);
    localparam int unsigned HW = $clog2(N_HIDDEN);
    localparam int unsigned IW = $clog2(N_IN);
    localparam int unsigned BW = $clog2(DATA_W);

    localparam logic [HW-1:0] HLast = HW'(N_HIDDEN - 1);
    localparam logic [IW-1:0] ILast = IW'(N_IN - 1);
    localparam logic [BW-1:0] BLast = BW'(DATA_W - 1);

    mac_state_t                  r_state;
    logic [HW-1:0]               r_h;
    logic [IW-1:0]               r_i;
    logic [BW-1:0]               r_b;
    logic [N_IN-1:0][DATA_W-1:0] r_x;
    logic [AW-1:0]               r_raddr;
    logic                        r_busy;
    logic                        r_out_valid;
    logic [HW-1:0]               r_out_idx;
    logic [ACC_W-1:0]            r_out_acc;
    logic                        r_done;

    logic                        w_accept;
    logic                        w_handshake;
    logic                        w_clr;
    logic                        w_load_w;
    logic                        w_bit_en;
    logic                        w_x_bit;
    logic                        w_is_msb;
    logic [ACC_W-1:0]            w_acc_nxt;

    always_comb begin
        w_accept    = (r_state == StIdle) && bus.start;
        w_handshake = (r_state == StOut) && bus.out_ready;
        w_clr       = w_accept || (w_handshake && (r_h != HLast));
        w_load_w    = (r_state == StWait);
        w_bit_en    = (r_state == StShift);
        w_x_bit     = r_x[r_i][r_b];
        w_is_msb    = (r_b == BLast);
    end

    bit_serial_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .BW     (BW)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_clr),
        .i_load_w  (w_load_w),
        .i_bit_en  (w_bit_en),
        .i_bit_idx (r_b),
        .i_x_bit   (w_x_bit),
        .i_is_msb  (w_is_msb),
        .i_w       (bus.rdata),
        .o_acc_nxt (w_acc_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_h         <= '0;
            r_i         <= '0;
            r_b         <= '0;
            r_x         <= '0;
            r_raddr     <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_acc   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_x     <= bus.x_in;
                        r_h     <= '0;
                        r_i     <= '0;
                        r_raddr <= AW'(waddr(0, 0, N_IN));
                        r_busy  <= 1'b1;
                        r_state <= StFetch;
                    end
                end
                StFetch: begin
                    r_state <= StWait;
                end
                StWait: begin
                    r_b     <= '0;
                    r_state <= StShift;
                end
                StShift: begin
                    r_b <= r_b + 1'b1;
                    if (r_b == BLast) begin
                        if (r_i != ILast) begin
                            r_i     <= r_i + 1'b1;
                            r_raddr <= AW'(waddr(32'(r_h), 32'(r_i) + 32'd1, N_IN));
                            r_state <= StFetch;
                        end else begin
                            // Capture the post-step value; the MAC register updates this edge.
                            r_out_valid <= 1'b1;
                            r_out_idx   <= r_h;
                            r_out_acc   <= w_acc_nxt;
                            r_state     <= StOut;
                        end
                    end
                end
                StOut: begin
                    if (w_handshake) begin
                        r_out_valid <= 1'b0;
                        if (r_h != HLast) begin
                            r_h     <= r_h + 1'b1;
                            r_i     <= '0;
                            r_raddr <= AW'(waddr(32'(r_h) + 32'd1, 0, N_IN));
                            r_state <= StFetch;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.raddr     = r_raddr;
    assign bus.busy      = r_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.out_idx   = r_out_idx;
    assign bus.done      = r_done;

`ifdef HIDDEN_MAC_RELU_EN
    assign bus.out_acc = r_out_acc[ACC_W-1] ? '0 : r_out_acc;
`else
    assign bus.out_acc = r_out_acc;
`endif

endmodule

// File: tb/tb_hidden_mac_seq.sv
// Self-checking bench for hidden_mac_seq: table of directed and random vectors checked
// against a plain-arithmetic dot-product model, plus reset-in-flight sequence.
module tb_hidden_mac_seq;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned N_IN     = 8;
    localparam int unsigned N_HIDDEN = 4;
    localparam int unsigned ACC_W    = 2 * DATA_W + $clog2(N_IN);
    localparam int unsigned NW       = N_HIDDEN * N_IN;
    localparam int unsigned AW       = $clog2(NW);
    localparam int unsigned NVEC     = 6;

    typedef struct packed {
        logic [NW-1:0][DATA_W-1:0]       w;
        logic [N_IN-1:0][DATA_W-1:0]     x;
        logic [31:0]                     stall;
        logic [N_HIDDEN-1:0][63:0]       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [DATA_W-1:0] mem [NW];
    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs [NVEC];

    hidden_mac_seq_if #(
        .DATA_W   (DATA_W),
        .N_IN     (N_IN),
        .N_HIDDEN (N_HIDDEN),
        .ACC_W    (ACC_W)
    ) bus ();

    hidden_mac_seq #(
        .DATA_W   (DATA_W),
        .N_IN     (N_IN),
        .N_HIDDEN (N_HIDDEN),
        .ACC_W    (ACC_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Weight memory with 1-cycle read latency.
    always @(posedge clk) bus.rdata <= mem[bus.raddr];

    task automatic check(input string nm, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic signed [63:0] relu(input logic signed [63:0] a);
`ifdef HIDDEN_MAC_RELU_EN
        return (a < 0) ? 64'sd0 : a;
`else
        return a;
`endif
    endfunction

    function automatic logic signed [63:0] model(input vec_t v, input int h);
        logic signed [63:0] s = 0;
        for (int i = 0; i < N_IN; i++) begin
            s += 64'($signed(v.x[i])) * 64'($signed(v.w[h*N_IN+i]));
        end
        return s;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int            cnt;
        logic [AW-1:0] ra;
        logic [AW-1:0] q[$];
        for (int k = 0; k < NW; k++) mem[k] = v.w[k];
        bus.out_ready = (v.stall == 0);
        bus.x_in      = v.x;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cnt = 1;
        check($sformatf("%s busy_rise", tag), 64'(bus.busy), 1);
        for (int h = 0; h < N_HIDDEN; h++) begin
            q.delete();
            while (!bus.out_valid && cnt < 2000) begin
                if (h == 0) begin
                    if (q.size() == 0 || q[$] != bus.raddr) q.push_back(bus.raddr);
                    // A start while busy, with different data, must be ignored.
                    bus.start = (cnt == 50);
                    if (cnt == 50) bus.x_in = ~v.x;
                end
                @(posedge clk); #1;
                cnt++;
            end
            bus.start = 1'b0;
            if (!bus.out_valid) begin
                check($sformatf("%s out_valid_timeout h%0d", tag, h), 0, 1);
                return;
            end
            if (h == 0) begin
                check($sformatf("%s latency", tag), 64'(cnt), 145);
                check($sformatf("%s raddr_count", tag), 64'(q.size()), 64'(N_IN));
                for (int k = 0; k < q.size() && k < N_IN; k++) begin
                    check($sformatf("%s raddr[%0d]", tag, k), 64'(q[k]), 64'(k));
                end
            end
            ra = bus.raddr;
            check($sformatf("%s idx h%0d", tag, h), 64'(bus.out_idx), 64'(h));
            check($sformatf("%s acc h%0d", tag, h), 64'($signed(bus.out_acc)),
                  relu($signed(v.exp[h])));
            for (int s = 0; s < int'(v.stall); s++) begin
                @(posedge clk); #1;
                check($sformatf("%s hold_valid h%0d", tag, h), 64'(bus.out_valid), 1);
                check($sformatf("%s hold_idx h%0d", tag, h), 64'(bus.out_idx), 64'(h));
                check($sformatf("%s hold_acc h%0d", tag, h), 64'($signed(bus.out_acc)),
                      relu($signed(v.exp[h])));
                check($sformatf("%s hold_raddr h%0d", tag, h), 64'(bus.raddr), 64'(ra));
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = (v.stall == 0);
            check($sformatf("%s valid_drop h%0d", tag, h), 64'(bus.out_valid), 0);
            check($sformatf("%s done h%0d", tag, h), 64'(bus.done),
                  (h == N_HIDDEN - 1) ? 1 : 0);
        end
        @(posedge clk); #1;
        check($sformatf("%s done_fall", tag), 64'(bus.done), 0);
        check($sformatf("%s busy_fall", tag), 64'(bus.busy), 0);
    endtask

    initial begin
        int cnt;
        bus.start     = 1'b0;
        bus.x_in      = '0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < NW; k++) mem[k] = '0;

        for (int v = 0; v < NVEC; v++) begin
            vecs[v] = '0;
            for (int h = 0; h < N_HIDDEN; h++)
                for (int i = 0; i < N_IN; i++)
                    vecs[v].w[h*N_IN+i] = DATA_W'(h * 10 + i + 1);
        end
        // Positive weights, x = 1
        for (int i = 0; i < N_IN; i++) vecs[0].x[i] = 16'd1;
        vecs[0].exp[0] = 64'(36);   vecs[0].exp[1] = 64'(116);
        vecs[0].exp[2] = 64'(196);  vecs[0].exp[3] = 64'(276);
        // Negative activations
        for (int i = 0; i < N_IN; i++) vecs[1].x[i] = 16'hFFFF;
        vecs[1].exp[0] = -64'sd36;  vecs[1].exp[1] = -64'sd116;
        vecs[1].exp[2] = -64'sd196; vecs[1].exp[3] = -64'sd276;
        // Extreme operands
        vecs[2].w[0] = 16'h8000;
        vecs[2].x[0] = 16'h8000;
        vecs[2].exp[0] = 64'sd1073741824; vecs[2].exp[1] = -64'sd360448;
        vecs[2].exp[2] = -64'sd688128;    vecs[2].exp[3] = -64'sd1015808;
        // Backpressure
        vecs[3] = vecs[0];
        vecs[3].stall = 32'd10;
        // Random
        for (int v = 4; v < NVEC; v++) begin
            for (int k = 0; k < NW; k++) vecs[v].w[k] = DATA_W'($urandom);
            for (int i = 0; i < N_IN; i++) vecs[v].x[i] = DATA_W'($urandom);
            vecs[v].stall = $urandom_range(0, 3);
            for (int h = 0; h < N_HIDDEN; h++) vecs[v].exp[h] = model(vecs[v], h);
        end

        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(bus.busy), 0);
        check("reset out_valid", 64'(bus.out_valid), 0);
        check("reset raddr", 64'(bus.raddr), 0);
        check("reset out_idx", 64'(bus.out_idx), 0);
        check("reset out_acc", 64'($signed(bus.out_acc)), 0);
        check("reset done", 64'(bus.done), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < NVEC; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

        // Reset in flight
        for (int k = 0; k < NW; k++) mem[k] = vecs[0].w[k];
        bus.out_ready = 1'b1;
        bus.x_in      = vecs[0].x;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cnt = 1;
        while (cnt < 300) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("midrst busy_before", 64'(bus.busy), 1);
        rst = 1'b1;
        #1;
        check("midrst busy", 64'(bus.busy), 0);
        check("midrst out_valid", 64'(bus.out_valid), 0);
        check("midrst raddr", 64'(bus.raddr), 0);
        check("midrst out_acc", 64'($signed(bus.out_acc)), 0);
        check("midrst done", 64'(bus.done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_vec(vecs[0], "post_rst0");
        run_vec(vecs[4], "post_rst4");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
